// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Decides when the LED string drivers may start shifting a frame, in the
// 20 MHz pixel clock domain. A frame starts only when all of these hold:
//   - the pixel FIFO holds at least one complete frame,
//   - the previous frame has drained from the line,
//   - the WS2812 latch gap has elapsed,
//   - the optional frame-period pacing timer has expired.
// The block also returns frame and late-frame counters to the register file.
//
// All outputs are registered. frame_start is high during the START state,
// which is the cycle after the WAIT_DATA start condition is seen. The frame
// counter, the period timer and late_armed are updated on the edge that
// enters START, so that frame_start and the reloaded period timer appear
// together. This gives a frame_start spacing of exactly frame_period cycles.
//
// Ports:
//   clk              20 MHz pixel clock; the block's only clock
//   reset            asynchronous, active-high
//   enable           level; the scheduler runs while high
//   frame_period     minimum cycles between frame_start pulses (0 = unpaced)
//   fifo_full_count  words available in the pixel FIFO
//   string_active    high while the string drivers shift a frame
//   frame_start      one-cycle pulse to the string drivers' h_blank_in
//   busy             high in any state other than IDLE
//   frame_count      frames started; wraps
//   late_count       frames whose period expired before data; saturates
//   start_err        one-cycle pulse when string_active failed to rise
//   state            current state encoding, for debug readback
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int FIFO_ADDR_WIDTH = 12,
    parameter int FRAME_WORDS     = 24,
    parameter int LATCH_CYCLES    = 1200,
    parameter int START_TIMEOUT   = 16,   // must be >= 2
    parameter int PERIOD_WIDTH    = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [PERIOD_WIDTH-1:0]  frame_period,
    input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
    input  logic                     string_active,
    output logic                     frame_start,
    output logic                     busy,
    output logic [15:0]              frame_count,
    output logic [15:0]              late_count,
    output logic                     start_err,
    output logic [2:0]               state
);

    localparam int CNT_W   = FIFO_ADDR_WIDTH + 1;
    localparam int LATCH_W = $clog2(LATCH_CYCLES + 1);
    localparam int TO_W    = $clog2(START_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   FRAME_WORDS_C = CNT_W'(FRAME_WORDS);
    localparam logic [LATCH_W-1:0] LATCH_LOAD_C  = LATCH_W'(LATCH_CYCLES - 1);
    // The START cycle is the first cycle of the timeout window, so the
    // ACTIVE phase-A counter gives up after START_TIMEOUT-1 cycles.
    localparam logic [TO_W-1:0]    TO_LAST_C     = TO_W'(START_TIMEOUT - 2);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_START     = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_LATCH     = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [PERIOD_WIDTH-1:0] period_timer_r;
    logic [LATCH_W-1:0]      latch_cnt_r;
    logic [TO_W-1:0]         to_cnt_r;
    logic                    rise_seen_r;
    logic                    late_armed_r;
    logic                    frame_start_r;
    logic                    busy_r;
    logic                    start_err_r;
    logic [15:0]             frame_count_r;
    logic [15:0]             late_count_r;

    logic data_ready_s;
    logic period_done_s;
    logic latch_done_s;
    logic timeout_s;
    logic timeout_fire_s;
    logic late_hit_s;

    assign data_ready_s  = (fifo_full_count >= FRAME_WORDS_C);
    assign period_done_s = (period_timer_r == {PERIOD_WIDTH{1'b0}});
    assign latch_done_s  = (latch_cnt_r == {LATCH_W{1'b0}});
    assign timeout_s     = (to_cnt_r == TO_LAST_C);

    // A late frame: the period expired while data is still short. Counted
    // once per frame; suppressed after IDLE (late_armed preset) and when
    // pacing is off.
    assign late_hit_s = (state_r == ST_WAIT_DATA) && enable && period_done_s &&
                        !data_ready_s && !late_armed_r &&
                        (frame_period != {PERIOD_WIDTH{1'b0}});

    // Next-state decode and timeout detection.
    always_comb begin
        next_state_s   = state_r;
        timeout_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    next_state_s = ST_WAIT_DATA;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (!enable) begin
                    next_state_s = ST_IDLE;
                end else if (data_ready_s && period_done_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_WAIT_DATA;
                end
            end
            ST_START: begin
                next_state_s = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!rise_seen_r) begin
                    // Phase A: waiting for the drivers to pick up the frame.
                    if (string_active) begin
                        next_state_s = ST_ACTIVE;
                    end else if (timeout_s) begin
                        next_state_s   = ST_LATCH;
                        timeout_fire_s = 1'b1;
                    end else begin
                        next_state_s = ST_ACTIVE;
                    end
                end else begin
                    // Phase B: waiting for the frame to drain; no timeout.
                    if (!string_active) begin
                        next_state_s = ST_LATCH;
                    end else begin
                        next_state_s = ST_ACTIVE;
                    end
                end
            end
            ST_LATCH: begin
                if (!latch_done_s) begin
                    next_state_s = ST_LATCH;
                end else if (enable) begin
                    next_state_s = ST_WAIT_DATA;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered status outputs, decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            start_err_r   <= 1'b0;
        end else begin
            frame_start_r <= (next_state_s == ST_START);
            busy_r        <= (next_state_s != ST_IDLE);
            start_err_r   <= timeout_fire_s;
        end
    end

    // Frame counter (wraps) and late counter (saturates).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_r <= 16'd0;
            late_count_r  <= 16'd0;
        end else begin
            if (next_state_s == ST_START) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (late_hit_s && (late_count_r != 16'hFFFF)) begin
                late_count_r <= late_count_r + 16'd1;
            end
        end
    end

    // late_armed: preset in IDLE so the first frame is never late, cleared at
    // each START, set once a late frame has been counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            late_armed_r <= 1'b1;
        end else if (state_r == ST_IDLE) begin
            late_armed_r <= 1'b1;
        end else if (next_state_s == ST_START) begin
            late_armed_r <= 1'b0;
        end else if (late_hit_s) begin
            late_armed_r <= 1'b1;
        end
    end

    // Period timer: loaded on entry to START, held at 0 in IDLE, otherwise
    // counts down to 0 and saturates there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_timer_r <= {PERIOD_WIDTH{1'b0}};
        end else if (next_state_s == ST_START) begin
            if (frame_period == {PERIOD_WIDTH{1'b0}}) begin
                period_timer_r <= {PERIOD_WIDTH{1'b0}};
            end else begin
                period_timer_r <= frame_period - PERIOD_WIDTH'(1);
            end
        end else if (state_r == ST_IDLE) begin
            period_timer_r <= {PERIOD_WIDTH{1'b0}};
        end else if (!period_done_s) begin
            period_timer_r <= period_timer_r - PERIOD_WIDTH'(1);
        end
    end

    // Latch-gap counter: loaded on entry to LATCH, counts down to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_cnt_r <= {LATCH_W{1'b0}};
        end else if ((next_state_s == ST_LATCH) && (state_r != ST_LATCH)) begin
            latch_cnt_r <= LATCH_LOAD_C;
        end else if ((state_r == ST_LATCH) && !latch_done_s) begin
            latch_cnt_r <= latch_cnt_r - LATCH_W'(1);
        end
    end

    // ACTIVE phase tracking: rise_seen marks phase B, to_cnt times phase A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r    <= {TO_W{1'b0}};
            rise_seen_r <= 1'b0;
        end else if ((next_state_s == ST_ACTIVE) && (state_r != ST_ACTIVE)) begin
            to_cnt_r    <= {TO_W{1'b0}};
            rise_seen_r <= 1'b0;
        end else if ((state_r == ST_ACTIVE) && !rise_seen_r) begin
            if (string_active) begin
                rise_seen_r <= 1'b1;
            end else if (!timeout_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end

    assign frame_start = frame_start_r;
    assign busy        = busy_r;
    assign start_err   = start_err_r;
    assign frame_count = frame_count_r;
    assign late_count  = late_count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Directed bench for frame_scheduler. Inputs are driven and outputs sampled
// on the falling clock edge. "cycle n" is the interval after the n-th rising
// edge: an input set at the falling edge of cycle n is what the DUT sees
// during cycle n, and registered outputs read in cycle n were updated at the
// rising edge that opened it.
//
// Hand-derived timing used below (F = cycle in which frame_start is high):
//   - string_active seen low in cycle A (phase B): LATCH holds for cycles
//     A+1..A+1200, WAIT_DATA at A+1201, next frame_start at A+1202.
//   - string_active never rises: start_err in cycle F+16 together with
//     LATCH entry, LATCH F+16..F+1215, next frame_start at F+1217.
//   - period P: timer is P-1 in cycle F and 0 in F+P-1, next start at F+P.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [19:0] frame_period;
    logic [12:0] fifo_full_count;
    logic        string_active;
    logic        frame_start;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] late_count;
    logic        start_err;
    logic [2:0]  state;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    frame_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .frame_period    (frame_period),
        .fifo_full_count (fifo_full_count),
        .string_active   (string_active),
        .frame_start     (frame_start),
        .busy            (busy),
        .frame_count     (frame_count),
        .late_count      (late_count),
        .start_err       (start_err),
        .state           (state)
    );

    // 20 MHz clock.
    always #25 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #20ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Bounded wait for a frame_start pulse; returns the cycle it was seen in.
    task automatic wait_start(input string tag, input int budget, output int at);
        logic found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        string_active = 1'b0;
        fifo_full_count = 13'd0;
        frame_period = 20'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int f1, f2, f3, fall, bad, n0;

        // ---------------- reset state ----------------
        reset = 1'b1;
        enable = 1'b0;
        string_active = 1'b0;
        fifo_full_count = 13'd0;
        frame_period = 20'd0;
        repeat (2) @(negedge clk);
        check("rst frame_start", 32'(frame_start), 32'd0);
        check("rst busy",        32'(busy),        32'd0);
        check("rst frame_count", 32'(frame_count), 32'd0);
        check("rst late_count",  32'(late_count),  32'd0);
        check("rst start_err",   32'(start_err),   32'd0);
        check("rst state",       32'(state),       32'd0);

        // ---------------- 1: basic frame + latch gap ----------------
        do_reset();
        fifo_full_count = 13'd24;
        enable = 1'b1;
        wait_start("t1 start1", 20, f1);
        check("t1 count1", 32'(frame_count), 32'd1);
        wait_to(f1 + 1);
        check("t1 pulse width", 32'(frame_start), 32'd0);
        check("t1 active", 32'(state), 32'd3);
        wait_to(f1 + 2);
        string_active = 1'b1;
        wait_to(f1 + 50);
        string_active = 1'b0;
        fall = f1 + 50;
        wait_to(fall + 1);
        check("t1 latch first", 32'(state), 32'd4);
        wait_to(fall + 1200);
        check("t1 latch last", 32'(state), 32'd4);
        wait_to(fall + 1201);
        check("t1 wait_data", 32'(state), 32'd1);
        wait_start("t1 start2", 10, f2);
        check("t1 spacing", 32'(f2 - fall), 32'd1202);
        check("t1 count2", 32'(frame_count), 32'd2);

        // ---------------- 2: threshold boundary 23/24 ----------------
        do_reset();
        fifo_full_count = 13'd23;
        enable = 1'b1;
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (frame_start !== 1'b0) bad++;
        end
        check("t2 no start at 23", 32'(bad), 32'd0);
        check("t2 busy", 32'(busy), 32'd1);
        check("t2 state", 32'(state), 32'd1);
        check("t2 late", 32'(late_count), 32'd0);
        fifo_full_count = 13'd24;
        n0 = cyc;
        @(negedge clk);
        check("t2 next cycle", 32'(cyc - n0), 32'd1);
        check("t2 start at 24", 32'(frame_start), 32'd1);
        check("t2 count", 32'(frame_count), 32'd1);

        // ---------------- 3: pacing at 4000 cycles ----------------
        do_reset();
        frame_period = 20'd4000;
        fifo_full_count = 13'd24;
        enable = 1'b1;
        wait_start("t3 start1", 20, f1);
        wait_to(f1 + 2);
        string_active = 1'b1;
        wait_to(f1 + 600);
        string_active = 1'b0;
        wait_start("t3 start2", 4100, f2);
        check("t3 spacing1", 32'(f2 - f1), 32'd4000);
        wait_to(f2 + 2);
        string_active = 1'b1;
        wait_to(f2 + 600);
        string_active = 1'b0;
        wait_start("t3 start3", 4100, f3);
        check("t3 spacing2", 32'(f3 - f2), 32'd4000);
        check("t3 late", 32'(late_count), 32'd0);
        check("t3 count", 32'(frame_count), 32'd3);

        // ---------------- 4: late frame ----------------
        do_reset();
        frame_period = 20'd2000;
        fifo_full_count = 13'd24;
        enable = 1'b1;
        wait_start("t4 start1", 20, f1);
        fifo_full_count = 13'd10;
        wait_to(f1 + 2);
        string_active = 1'b1;
        wait_to(f1 + 50);
        string_active = 1'b0;
        wait_to(f1 + 1999);
        check("t4 late before expiry", 32'(late_count), 32'd0);
        wait_to(f1 + 2000);
        check("t4 late at expiry", 32'(late_count), 32'd1);
        wait_to(f1 + 3000);
        check("t4 late once", 32'(late_count), 32'd1);
        check("t4 waiting", 32'(state), 32'd1);
        fifo_full_count = 13'd24;
        @(negedge clk);
        check("t4 start after data", 32'(frame_start), 32'd1);
        check("t4 count", 32'(frame_count), 32'd2);
        check("t4 late final", 32'(late_count), 32'd1);

        // ---------------- 5: start timeout ----------------
        do_reset();
        fifo_full_count = 13'd24;
        enable = 1'b1;
        wait_start("t5 start1", 20, f1);
        wait_to(f1 + 15);
        check("t5 no err early", 32'(start_err), 32'd0);
        check("t5 still active", 32'(state), 32'd3);
        wait_to(f1 + 16);
        check("t5 err pulse", 32'(start_err), 32'd1);
        check("t5 latch", 32'(state), 32'd4);
        wait_to(f1 + 17);
        check("t5 err one cycle", 32'(start_err), 32'd0);
        wait_to(f1 + 1215);
        check("t5 latch last", 32'(state), 32'd4);
        wait_start("t5 retry", 10, f2);
        check("t5 retry spacing", 32'(f2 - f1), 32'd1217);
        check("t5 count2", 32'(frame_count), 32'd2);
        wait_start("t5 retry2", 1300, f3);
        check("t5 count3", 32'(frame_count), 32'd3);

        // ---------------- 6: enable drop mid-frame, async reset ----------------
        do_reset();
        fifo_full_count = 13'd24;
        enable = 1'b1;
        wait_start("t6 start1", 20, f1);
        wait_to(f1 + 2);
        string_active = 1'b1;
        wait_to(f1 + 10);
        enable = 1'b0;
        wait_to(f1 + 40);
        check("t6 not truncated", 32'(state), 32'd3);
        wait_to(f1 + 50);
        string_active = 1'b0;
        fall = f1 + 50;
        wait_to(fall + 1200);
        check("t6 latch completes", 32'(state), 32'd4);
        check("t6 busy in latch", 32'(busy), 32'd1);
        wait_to(fall + 1201);
        check("t6 idle", 32'(state), 32'd0);
        check("t6 not busy", 32'(busy), 32'd0);
        check("t6 count", 32'(frame_count), 32'd1);

        enable = 1'b1;
        wait_start("t6 start2", 20, f2);
        wait_to(f2 + 2);
        string_active = 1'b1;
        wait_to(f2 + 20);
        string_active = 1'b0;
        wait_to(f2 + 100);
        check("t6 in latch", 32'(state), 32'd4);
        check("t6 count2", 32'(frame_count), 32'd2);
        #5;
        reset = 1'b1;
        #1;
        check("t6 async state", 32'(state), 32'd0);
        check("t6 async busy", 32'(busy), 32'd0);
        check("t6 async count", 32'(frame_count), 32'd0);
        check("t6 async start", 32'(frame_start), 32'd0);
        check("t6 async err", 32'(start_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
